disparity_wta_select: RTL and testbench
=======================================

# disparity_wta_select

Winner-take-all disparity selector directly downstream of the Hamming-distance stage. It consumes the stream of per-candidate costs for each pixel and tracks the minimum and second-minimum cost across the candidate sweep. At the last candidate it emits the winning disparity, the best cost, and a uniqueness-confidence flag. Its output feeds the disparity-map writer.

## Interface
- NUM_DISP, 64: candidates per pixel; legal range 2..256.
- COST_W, 8: cost width; matches the Hamming stage `sum`.
- MARGIN, 4: uniqueness margin, in cost units.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cost_i  in  COST_W  candidate cost (Hamming `sum`).
- cost_valid_i  in  1  cost_i, coords_i and blk_index_i valid this cycle.
- coords_i  in  16  pixel coordinates {y[15:8], x[7:0]}.
- blk_index_i  in  16  candidate index (disparity); only [7:0] used, [15:8] must be 0.
- disp_o  out  8  winning disparity.
- best_cost_o  out  COST_W  minimum cost.
- coords_o  out  16  coordinates of the resolved pixel.
- confident_o  out  1  second_min >= best + MARGIN.
- disp_valid_o  out  1  single-cycle strobe; outputs above are valid.
- seq_err_o  out  1  single-cycle strobe on a protocol violation.

## Operation
- There is no backpressure. Input beats may have arbitrary idle gaps, where cost_valid_i is low.
- State IDLE:
  - Beat with index 0 → latch coords, best = cost, best_idx = 0, second = all-ones, expected index = 1 → go to ACCUM.
  - Beat with index ≠ 0 → seq_err_o pulse, stay in IDLE, beat dropped.
- State ACCUM:
  - Each valid beat must have index == expected and coords == latched coords.
  - Update on a legal beat:
    - cost < best → second = best, best = cost, best_idx = index.
    - Else if cost < second → second = cost.
  - Ties keep the lower disparity, because the comparison is strict.
  - Legal beat with index == NUM_DISP-1 → apply the update, emit the result, go to IDLE.
- Violations in ACCUM:
  - Index 0 arrives → seq_err_o pulse. The partial pixel is discarded with no disp_valid_o, and the beat starts a new pixel; stay in ACCUM.
  - Any other mismatch (wrong index, changed coords) → seq_err_o pulse, partial pixel discarded, go to IDLE. The beat is dropped.
- Arithmetic for confident_o: best + MARGIN is computed at COST_W+1 bits, so there is no wrap. If second == all-ones and it was never updated, it still compares numerically.
- Reset can arrive mid-pixel. The partial pixel is discarded with no output and no error, and the state returns to IDLE.

## Timing
- Latency: the result is registered. disp_valid_o is high on the cycle after the beat with index NUM_DISP-1 is accepted.
- Pixels may be back-to-back. Index 0 of the next pixel may arrive on the cycle right after the previous pixel's last beat, including the cycle where disp_valid_o is high, with no bubble.
- disp_o, best_cost_o, coords_o and confident_o hold their values until the next disp_valid_o.
- seq_err_o rises one cycle after the offending beat.
- Reset values: disp_o = 0, best_cost_o = 0, coords_o = 0, confident_o = 0, disp_valid_o = 0, seq_err_o = 0, state = IDLE.
- Throughput: one candidate per cycle.

## Structure
- Shared package `bm_pkg` holds:
  - COST_W default;
  - typedef coords_t, packed [1:0][7:0];
  - typedef disp_t, [7:0];
  - state enum {IDLE, ACCUM}.
- One combinational sub-module, `min2_update`. It takes (best, best_idx, second, cost, idx) and returns the updated triple. It is reusable by a future left-right consistency stage.
- Size: roughly 150–250 lines of RTL in total.

## Test plan
- Nominal pixel:
  - Stimulus: NUM_DISP = 4, coords 0x0305, costs [20, 9, 30, 15] at indices 0..3, back-to-back.
  - Required: one cycle later disp_o = 1, best_cost_o = 9, coords_o = 0x0305, confident_o = 1 (15 >= 13), disp_valid_o high for 1 cycle.
- Tie and low confidence:
  - Stimulus: costs [7, 7, 9, 40].
  - Required: disp_o = 0, best_cost_o = 7, confident_o = 0.
- Gaps and back-to-back pixels:
  - Stimulus: pixel A sent with random valid gaps; pixel B's index 0 arrives on the cycle after A's last beat.
  - Required: both results are correct, and disp_valid_o pulses are exactly 1 cycle apart from the accepted last beats.
- Sequence errors:
  - Stimulus 1: in ACCUM, index 2 arrives when 1 is expected. Required: seq_err_o pulse, no disp_valid_o, state returns to IDLE.
  - Stimulus 2: index 0 arrives mid-pixel. Required: seq_err_o pulse, and the new pixel then completes correctly.
- Reset mid-pixel:
  - Stimulus: assert reset after 2 beats, then send a full pixel.
  - Required: all outputs read 0 after reset, no seq_err_o, and only the new pixel's result appears.
- Maximum cost:
  - Stimulus: all costs 255.
  - Required: disp_o = 0, best_cost_o = 255, confident_o = 0 (255 < 259).

Source files
------------

// File: rtl/bm_pkg.sv
// bm_pkg: types and defaults shared by the block-matching pipeline stages.
//   COST_W_DEF : default matching-cost width, equal to the Hamming-stage sum width.
//   coords_t   : pixel coordinates, with [1] = y and [0] = x.
//   disp_t     : disparity / candidate index.
//   state_e    : per-pixel sweep state of the winner-take-all selector.
package bm_pkg;

  localparam int COST_W_DEF = 8;

  typedef logic [1:0][7:0] coords_t;
  typedef logic [7:0]      disp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/min2_update.sv
// min2_update: a purely combinational step that tracks the minimum and second-minimum.
// It folds one (cost, idx) candidate into a running (best, best_idx, second) triple.
// Comparisons are strict, so on a tie the earlier (lower) index keeps the win.
//   best_i, best_idx_i, second_i : running triple before this candidate.
//   cost_i, idx_i                : candidate cost and its disparity.
//   best_o, best_idx_o, second_o : updated triple.
module min2_update
  import bm_pkg::*;
#(
  parameter int COST_W = COST_W_DEF
) (
  input  logic [COST_W-1:0] best_i,
  input  disp_t             best_idx_i,
  input  logic [COST_W-1:0] second_i,
  input  logic [COST_W-1:0] cost_i,
  input  disp_t             idx_i,
  output logic [COST_W-1:0] best_o,
  output disp_t             best_idx_o,
  output logic [COST_W-1:0] second_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (cost_i < best_i) begin
      second_o   = best_i;
      best_o     = cost_i;
      best_idx_o = idx_i;
    end else if (cost_i < second_i) begin
      second_o   = cost_i;
    end
  end

endmodule

// File: rtl/disparity_wta_select.sv
// disparity_wta_select: a winner-take-all disparity selector.
// It consumes one candidate cost per cycle for each pixel, with indices 0..NUM_DISP-1 in order.
// After the last candidate it emits the winning disparity, the best cost and a uniqueness
// flag. The flag is set when the second-best cost is at least best + MARGIN.
//
// Handshake: there is no backpressure. A beat is a cycle with cost_valid_i high, and every
// beat is consumed in the cycle it is presented. disp_valid_o and seq_err_o are one-cycle
// strobes, registered one cycle after the causing beat. The result outputs hold their values
// between disp_valid_o strobes.
//
// Ports:
//   clk, reset    : clock; synchronous active-high reset.
//   cost_i        : candidate cost.
//   cost_valid_i  : beat qualifier for cost_i, coords_i and blk_index_i.
//   coords_i      : pixel coordinates {y, x}.
//   blk_index_i   : candidate index. The upper byte must be zero.
//   disp_o        : winning disparity.
//   best_cost_o   : minimum cost.
//   coords_o      : coordinates of the resolved pixel.
//   confident_o   : second_min >= best + MARGIN.
//   disp_valid_o  : result strobe.
//   seq_err_o     : protocol-violation strobe.
//   state_o       : current sweep state, for observation.
module disparity_wta_select
  import bm_pkg::*;
#(
  parameter int NUM_DISP = 64,
  parameter int COST_W   = COST_W_DEF,
  parameter int MARGIN   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COST_W-1:0] cost_i,
  input  logic              cost_valid_i,
  input  logic [15:0]       coords_i,
  input  logic [15:0]       blk_index_i,
  output logic [7:0]        disp_o,
  output logic [COST_W-1:0] best_cost_o,
  output logic [15:0]       coords_o,
  output logic              confident_o,
  output logic              disp_valid_o,
  output logic              seq_err_o,
  output state_e            state_o
);

  localparam disp_t             LAST_IDX   = disp_t'(NUM_DISP - 1);
  localparam logic [COST_W:0]   MARGIN_EXT = (COST_W + 1)'(MARGIN);

  state_e            state;
  coords_t           cur_coords;
  logic [COST_W-1:0] best;
  disp_t             best_idx;
  logic [COST_W-1:0] second;
  disp_t             exp_idx;

  logic [COST_W-1:0] nxt_best;
  disp_t             nxt_best_idx;
  logic [COST_W-1:0] nxt_second;

  disp_t idx;
  logic  idx_hi_ok;
  logic  idx_zero;
  logic  beat_ok;
  logic  is_last;
  logic  conf_next;

  // A non-zero upper index byte can never be a legal index. Such a beat is treated as a
  // mismatch rather than being silently aliased onto [7:0].
  assign idx       = blk_index_i[7:0];
  assign idx_hi_ok = (blk_index_i[15:8] == 8'd0);
  assign idx_zero  = idx_hi_ok && (idx == 8'd0);
  assign beat_ok   = idx_hi_ok && (idx == exp_idx) && (coords_i == cur_coords);
  assign is_last   = (idx == LAST_IDX);

  min2_update #(.COST_W(COST_W)) u_min2 (
    .best_i     (best),
    .best_idx_i (best_idx),
    .second_i   (second),
    .cost_i     (cost_i),
    .idx_i      (idx),
    .best_o     (nxt_best),
    .best_idx_o (nxt_best_idx),
    .second_o   (nxt_second)
  );

  // The sum is one bit wider than the costs, so best + MARGIN cannot wrap. An untouched
  // all-ones second still compares by its numeric value.
  assign conf_next = ({1'b0, nxt_second} >= ({1'b0, nxt_best} + MARGIN_EXT));

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur_coords   <= '0;
      best         <= '0;
      best_idx     <= '0;
      second       <= '0;
      exp_idx      <= '0;
      disp_o       <= '0;
      best_cost_o  <= '0;
      coords_o     <= '0;
      confident_o  <= 1'b0;
      disp_valid_o <= 1'b0;
      seq_err_o    <= 1'b0;
    end else begin
      disp_valid_o <= 1'b0;
      seq_err_o    <= 1'b0;
      if (cost_valid_i) begin
        case (state)
          IDLE: begin
            if (idx_zero) begin
              cur_coords <= coords_i;
              best       <= cost_i;
              best_idx   <= '0;
              second     <= '1;
              exp_idx    <= 8'd1;
              state      <= ACCUM;
            end else begin
              seq_err_o  <= 1'b1;
            end
          end
          ACCUM: begin
            if (idx_zero) begin
              // An index-0 beat mid-sweep restarts the sweep. The partial pixel is dropped
              // and this beat becomes the first candidate of a new pixel.
              seq_err_o  <= 1'b1;
              cur_coords <= coords_i;
              best       <= cost_i;
              best_idx   <= '0;
              second     <= '1;
              exp_idx    <= 8'd1;
            end else if (beat_ok) begin
              best     <= nxt_best;
              best_idx <= nxt_best_idx;
              second   <= nxt_second;
              if (is_last) begin
                disp_o       <= nxt_best_idx;
                best_cost_o  <= nxt_best;
                coords_o     <= cur_coords;
                confident_o  <= conf_next;
                disp_valid_o <= 1'b1;
                state        <= IDLE;
              end else begin
                exp_idx <= exp_idx + 8'd1;
              end
            end else begin
              seq_err_o <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disparity_wta_select.sv
// tb_disparity_wta_select: directed bench for disparity_wta_select with NUM_DISP = 4.
module tb_disparity_wta_select;
  import bm_pkg::*;

  localparam int NUM_DISP = 4;
  localparam int COST_W   = 8;
  localparam int MARGIN   = 4;

  logic              clk;
  logic              reset;
  logic [COST_W-1:0] cost_i;
  logic              cost_valid_i;
  logic [15:0]       coords_i;
  logic [15:0]       blk_index_i;
  logic [7:0]        disp_o;
  logic [COST_W-1:0] best_cost_o;
  logic [15:0]       coords_o;
  logic              confident_o;
  logic              disp_valid_o;
  logic              seq_err_o;
  state_e            state_o;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int se_cnt = 0;
  int dv_base;
  int se_base;

  disparity_wta_select #(
    .NUM_DISP (NUM_DISP),
    .COST_W   (COST_W),
    .MARGIN   (MARGIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cost_i       (cost_i),
    .cost_valid_i (cost_valid_i),
    .coords_i     (coords_i),
    .blk_index_i  (blk_index_i),
    .disp_o       (disp_o),
    .best_cost_o  (best_cost_o),
    .coords_o     (coords_o),
    .confident_o  (confident_o),
    .disp_valid_o (disp_valid_o),
    .seq_err_o    (seq_err_o),
    .state_o      (state_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe counters, sampled away from the active edge
  always @(negedge clk) begin
    if (disp_valid_o) dv_cnt++;
    if (seq_err_o)    se_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat: present it, let the active edge consume it, and return 1 time unit after that edge.
  task automatic beat(input logic [15:0] idx, input logic [7:0] cost, input logic [15:0] xy);
    cost_valid_i = 1'b1;
    blk_index_i  = idx;
    cost_i       = cost;
    coords_i     = xy;
    @(posedge clk);
    #1;
    cost_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    cost_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic [7:0] bc,
                              input logic [15:0] xy, input logic conf);
    check({tag, "_valid"}, {31'd0, disp_valid_o}, 32'd1);
    check({tag, "_disp"},  {24'd0, disp_o},       {24'd0, d});
    check({tag, "_best"},  {24'd0, best_cost_o},  {24'd0, bc});
    check({tag, "_xy"},    {16'd0, coords_o},     {16'd0, xy});
    check({tag, "_conf"},  {31'd0, confident_o},  {31'd0, conf});
  endtask

  initial begin
    reset        = 1'b1;
    cost_valid_i = 1'b0;
    cost_i       = '0;
    coords_i     = '0;
    blk_index_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_disp",  {24'd0, disp_o},       32'd0);
    check("rst_best",  {24'd0, best_cost_o},  32'd0);
    check("rst_xy",    {16'd0, coords_o},     32'd0);
    check("rst_conf",  {31'd0, confident_o},  32'd0);
    check("rst_valid", {31'd0, disp_valid_o}, 32'd0);
    check("rst_err",   {31'd0, seq_err_o},    32'd0);
    check("rst_state", {31'd0, state_o},      {31'd0, IDLE});

    // Nominal pixel: costs 20,9,30,15 give best 9 @1, second 15 >= 13
    beat(0, 8'd20, 16'h0305);
    beat(1, 8'd9,  16'h0305);
    beat(2, 8'd30, 16'h0305);
    beat(3, 8'd15, 16'h0305);
    check_result("nom", 8'd1, 8'd9, 16'h0305, 1'b1);
    idle(1);
    check("nom_pulse", {31'd0, disp_valid_o}, 32'd0);
    check("nom_hold",  {24'd0, disp_o},       32'd1);

    // Tie keeps index 0; second 7 < 11 gives low confidence
    beat(0, 8'd7,  16'h0306);
    beat(1, 8'd7,  16'h0306);
    beat(2, 8'd9,  16'h0306);
    beat(3, 8'd40, 16'h0306);
    check_result("tie", 8'd0, 8'd7, 16'h0306, 1'b0);
    idle(1);

    // Pixel A with random gaps (best 20 @3, second 30 >= 24), then pixel B back-to-back
    beat(0, 8'd50, 16'h0102);
    idle($urandom_range(0, 3));
    beat(1, 8'd40, 16'h0102);
    idle($urandom_range(0, 3));
    beat(2, 8'd30, 16'h0102);
    idle($urandom_range(0, 3));
    beat(3, 8'd20, 16'h0102);
    check_result("gapA", 8'd3, 8'd20, 16'h0102, 1'b1);
    beat(0, 8'd5, 16'h0103);
    check("gapA_pulse", {31'd0, disp_valid_o}, 32'd0);
    beat(1, 8'd60, 16'h0103);
    beat(2, 8'd60, 16'h0103);
    beat(3, 8'd60, 16'h0103);
    check_result("b2bB", 8'd0, 8'd5, 16'h0103, 1'b1);
    idle(1);

    // Wrong index in ACCUM: the pixel is aborted and the state returns to IDLE
    dv_base = dv_cnt;
    beat(0, 8'd10, 16'h0400);
    beat(2, 8'd10, 16'h0400);
    check("skip_err",   {31'd0, seq_err_o}, 32'd1);
    check("skip_state", {31'd0, state_o},   {31'd0, IDLE});
    idle(1);
    check("skip_err_pulse", {31'd0, seq_err_o}, 32'd0);
    check("skip_no_dv",     dv_cnt,             dv_base);

    // Non-zero index while IDLE
    beat(1, 8'd10, 16'h0400);
    check("idle_err",   {31'd0, seq_err_o}, 32'd1);
    check("idle_state", {31'd0, state_o},   {31'd0, IDLE});
    idle(1);

    // Changed coordinates mid-pixel
    beat(0, 8'd10, 16'h0410);
    beat(1, 8'd10, 16'h0411);
    check("xy_err",   {31'd0, seq_err_o}, 32'd1);
    check("xy_state", {31'd0, state_o},   {31'd0, IDLE});
    idle(1);

    // Index 0 mid-pixel restarts; new pixel 10,3,8,100 gives best 3 @1, second 8 >= 7
    dv_base = dv_cnt;
    beat(0, 8'd50, 16'h0500);
    beat(1, 8'd1,  16'h0500);
    beat(0, 8'd10, 16'h0501);
    check("restart_err",   {31'd0, seq_err_o}, 32'd1);
    check("restart_state", {31'd0, state_o},   {31'd0, ACCUM});
    beat(1, 8'd3,  16'h0501);
    check("restart_err_clr", {31'd0, seq_err_o}, 32'd0);
    beat(2, 8'd8,  16'h0501);
    beat(3, 8'd100, 16'h0501);
    check_result("restart", 8'd1, 8'd3, 16'h0501, 1'b1);
    idle(1);
    check("restart_one_dv", dv_cnt, dv_base + 1);

    // Reset mid-pixel, then a full pixel 100,90,80,95: best 80 @2, second 90 >= 84
    dv_base = dv_cnt;
    se_base = se_cnt;
    beat(0, 8'd1, 16'h0600);
    beat(1, 8'd1, 16'h0600);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_disp",  {24'd0, disp_o},       32'd0);
    check("mid_rst_best",  {24'd0, best_cost_o},  32'd0);
    check("mid_rst_xy",    {16'd0, coords_o},     32'd0);
    check("mid_rst_conf",  {31'd0, confident_o},  32'd0);
    check("mid_rst_valid", {31'd0, disp_valid_o}, 32'd0);
    check("mid_rst_err",   {31'd0, seq_err_o},    32'd0);
    check("mid_rst_state", {31'd0, state_o},      {31'd0, IDLE});
    beat(0, 8'd100, 16'h0A0B);
    beat(1, 8'd90,  16'h0A0B);
    beat(2, 8'd80,  16'h0A0B);
    beat(3, 8'd95,  16'h0A0B);
    check_result("post_rst", 8'd2, 8'd80, 16'h0A0B, 1'b1);
    idle(1);
    check("post_rst_no_err", se_cnt, se_base);
    check("post_rst_one_dv", dv_cnt, dv_base + 1);

    // Maximum cost: 255 < 255 + 4 at 9 bits, so not confident
    beat(0, 8'd255, 16'h0C0D);
    beat(1, 8'd255, 16'h0C0D);
    beat(2, 8'd255, 16'h0C0D);
    beat(3, 8'd255, 16'h0C0D);
    check_result("maxc", 8'd0, 8'd255, 16'h0C0D, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
